shft_rx8bit: RTL
================

Name: shft_rx8bit

Overview:
- Serial-to-parallel receiver that pairs with the team's 8-bit shift-register transmitter.
- It detects the frame start, samples one serial bit per shift strobe, and reassembles the word.
- The completed word is presented on a double-buffered parallel output with a valid/ready handshake.
- It sits on the receive side of the serial shift link, between the serial line and the parallel consumer.

Parameters:
WIDTH, 8, data bits per frame (2..16)
MSB_FIRST, 1, 1 = first received bit lands in q[WIDTH-1]; 0 = first bit lands in q[0]

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  frame-start pulse from link, one cycle
shft  input  1  shift strobe; when high, sin is sampled this cycle
sin  input  1  serial data bit
q  output  WIDTH  received word (holding register)
q_valid  output  1  q holds an unconsumed word
q_ready  input  1  consumer accepts q when q_valid & q_ready
busy  output  1  frame in progress (state SHIFT)
ovr  output  1  sticky overrun flag
ovr_clr  input  1  clears ovr
par_err  output  1  parity error for word in q (see Optional Feature)

Behaviour:
- Reset is synchronous and active-high: rst=1 on a rising clk edge resets everything.
- Reset values: q=0, q_valid=0, busy=0, ovr=0, par_err=0, state=IDLE, bit counter=0, shift register=0.
- rst mid-frame discards the partial word. rst also drops any pending q.
- States:
  - IDLE: busy=0; shft and sin ignored. start=1 -> SHIFT, counter=0, shift register cleared.
  - SHIFT: busy=1. Each cycle with shft=1, sin is shifted in and counter increments.
    - MSB_FIRST=1: the register shifts left and sin enters bit 0.
    - MSB_FIRST=0: the register shifts right and sin enters bit WIDTH-1.
    - Cycles with shft=0 hold state (gaps allowed, no timeout).
  - Completion: shft=1 with counter==FRAME_BITS-1 -> capture the full word into q on the next edge. Set q_valid=1 and return to IDLE.
- FRAME_BITS = WIDTH, or WIDTH+1 with parity enabled.
- Latency: q/q_valid update on the edge that samples the last bit, so they are visible 1 cycle after the last shft strobe.
- start while in SHIFT: resync. Abort the current frame, counter=0, register cleared, stay in SHIFT. start has priority over a simultaneous shft (that bit is not sampled).
- start and shft together in IDLE: only start acts; the first bit is taken on a later shft.
- Handshake:
  - q_valid & q_ready clears q_valid on the next edge.
  - q and q_valid are stable while q_valid=1 and q_ready=0.
- Completion with q_valid=1 and q_ready=0 in the same cycle is an overrun:
  - The new word is dropped.
  - q and par_err keep the old word.
  - ovr is set to 1.
- Completion with q_valid=1 and q_ready=1 in the same cycle: the new word is loaded, q_valid stays 1, no overrun.
- ovr clears only on rst or ovr_clr=1. If ovr_clr and a new overrun occur in the same cycle, the set wins.
- The bit counter is $clog2(WIDTH+2) bits wide and never wraps past FRAME_BITS-1.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - Each frame carries one extra trailing even-parity bit after the WIDTH data bits.
  - The parity bit is not stored in q.
  - par_err = XOR of the WIDTH data bits and the parity bit, registered with q. It is valid while q_valid=1.
  - An overrun frame does not update par_err.
- Undefined:
  - FRAME_BITS=WIDTH.
  - par_err is tied 0.
  - No parity logic is generated.

Test Plan:
1. rst=1 for 2 cycles, then idle 5 cycles -> q=0x00, q_valid=0, busy=0, ovr=0 throughout.
2. MSB_FIRST=1: start, then 8 consecutive shft with sin=1,0,1,0,0,1,0,1 -> q=0xA5, q_valid=1 one cycle after the 8th strobe, busy=0. Hold q_ready=0 for 3 cycles -> q stays 0xA5. Pulse q_ready -> q_valid=0.
3. Gapped strobes: start, send 0x3C with shft=0 for 2 cycles between every bit -> q=0x3C. Assert start after bit 4 of 0xFF, then send 0x81 -> q=0x81 (resync); no partial 0xFF word appears.
4. Overrun: receive 0x11 and leave q_ready=0, then receive 0x22 -> q=0x11, ovr=1. Pulse ovr_clr -> ovr=0. Receive 0x33 with q_ready=1 on its completion cycle -> q=0x33, ovr=0.
5. Reset mid-frame: after 5 bits of 0xF0, rst=1 for 1 cycle -> busy=0, q_valid=0. A new frame 0x0F then yields q=0x0F.
6. RX_PARITY_EN defined: send 0xA5 + parity bit 0 -> par_err=0. Send 0xA5 + parity bit 1 -> par_err=1, q=0xA5.

Source files
------------

// File: rtl/shft_rx8bit.sv
// Serial-to-parallel receiver for the shift link; optional trailing even parity bit under RX_PARITY_EN.
// Latency: q/q_valid update on the edge that samples the last frame bit.
// Backpressure: q is held until q_valid & q_ready; a completion while q is still pending drops the new word and sets sticky ovr.
module shft_rx8bit #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             shft,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  input  logic             q_ready,
  output logic             busy,
  output logic             ovr,
  input  logic             ovr_clr,
  output logic             par_err
);

`ifdef RX_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             load;

  always_comb begin
    sr_nxt = sr;
    if (MSB_FIRST) sr_nxt = {sr[WIDTH-2:0], sin};
    else           sr_nxt = {sin, sr[WIDTH-1:1]};
  end

  // start outranks a simultaneous shft, so it suppresses completion too
  assign done = (state == SHIFT) && !start && shft && (cnt == CW'(FRAME_BITS - 1));
  assign load = done && (!q_valid || q_ready);
  assign busy = (state == SHIFT);

`ifdef RX_PARITY_EN
  // last strobe carries the parity bit; the data word is already complete in sr
  assign word = sr;
`else
  assign word = sr_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            cnt   <= '0;
            sr    <= '0;
          end
        end
        SHIFT: begin
          if (start) begin
            cnt <= '0;
            sr  <= '0;
          end else if (shft) begin
            if (done) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
            if (cnt < CW'(WIDTH)) sr <= sr_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      q_valid <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      if (q_valid && q_ready) q_valid <= 1'b0;
      if (load) begin
        q       <= word;
        q_valid <= 1'b1;
      end
      if (ovr_clr) ovr <= 1'b0;
      if (done && q_valid && !q_ready) ovr <= 1'b1;
    end
  end

`ifdef RX_PARITY_EN
  logic par_q;
  always_ff @(posedge clk) begin
    if (rst)       par_q <= 1'b0;
    else if (load) par_q <= (^sr) ^ sin;
  end
  assign par_err = par_q;
`else
  assign par_err = 1'b0;
`endif

endmodule
